// File: rtl/sram_port_initiator_if.sv
// Request/response and SRAM-side signals of the SRAM port initiator.
// master = the initiator itself, slave = upstream requester plus attached memory.
interface sram_port_initiator_if #(
    parameter int ADDR_WIDTH = 15
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [3:0]            req_be;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_rdata;
    logic                  CEN;
    logic                  WEN;
    logic [3:0]            BEN;
    logic [ADDR_WIDTH-1:0] A;
    logic [31:0]           D;
    logic [31:0]           Q;

    modport master (
        input  req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready, Q,
        output req_ready, rsp_valid, rsp_rdata, CEN, WEN, BEN, A, D
    );

    modport slave (
        output req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready, Q,
        input  req_ready, rsp_valid, rsp_rdata, CEN, WEN, BEN, A, D
    );
endinterface

// File: rtl/sram_port_initiator.sv
// Single-port SRAM initiator: optional post-reset zero-fill sweep, then
// valid/ready requests mapped onto the memory port with a 2-deep read FIFO.
module sram_port_initiator #(
    parameter int ADDR_WIDTH = 15,
    parameter int DEPTH      = 2**ADDR_WIDTH,
    parameter int INIT_EN    = 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    sram_port_initiator_if.master  bus,
    output logic                   init_done
);
    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;
    localparam logic [0:0] ST_RESET = (INIT_EN != 0) ? ST_INIT : ST_RUN;
    localparam logic [ADDR_WIDTH-1:0] SWEEP_LAST = ADDR_WIDTH'(DEPTH - 1);

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] sweep_q, sweep_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            count_q, count_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;

    logic                  in_init;
    logic                  in_run;
    logic [2:0]            occupancy;
    logic                  req_ready;
    logic                  accept;
    logic                  rd_accept;
    logic                  push;
    logic                  pop;
    logic [31:0]           entry_data [2];

    // Reset gates every output so the port is idle while RST is held.
    assign in_init   = !RST && (state_q == ST_INIT);
    assign in_run    = !RST && (state_q == ST_RUN);
    assign init_done = (INIT_EN != 0) ? in_run : 1'b1;

    // Read admission counts the read whose data arrives next cycle, so the
    // FIFO can never overflow and rsp_ready never reaches req_ready.
    assign occupancy = {1'b0, count_q} + {2'b00, inflight_q};
    assign req_ready = in_run && (bus.req_we || (occupancy < 3'd2));
    assign accept    = bus.req_valid && req_ready;
    assign rd_accept = accept && !bus.req_we;

    assign push          = inflight_q;
    assign bus.rsp_valid = !RST && (count_q != 2'd0);
    assign pop           = bus.rsp_valid && bus.rsp_ready;
    assign bus.req_ready = req_ready;
    assign bus.rsp_rdata = entry_data[rd_ptr_q];

    always_comb begin
        bus.CEN = 1'b1;
        bus.WEN = 1'b1;
        bus.BEN = 4'hF;
        bus.A   = '0;
        bus.D   = '0;
        if (in_init) begin
            bus.CEN = 1'b0;
            bus.WEN = 1'b0;
            bus.BEN = 4'h0;
            bus.A   = sweep_q;
        end else if (in_run) begin
            bus.A = bus.req_addr;
            bus.D = bus.req_wdata;
            if (accept) begin
                bus.CEN = 1'b0;
                bus.WEN = ~bus.req_we;
                bus.BEN = ~bus.req_be;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        sweep_d    = sweep_q;
        inflight_d = rd_accept;
        count_d    = count_q + {1'b0, push} - {1'b0, pop};
        wr_ptr_d   = push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d   = pop  ? ~rd_ptr_q : rd_ptr_q;
        if (state_q == ST_INIT) begin
            if (sweep_q == SWEEP_LAST) begin
                state_d = ST_RUN;
            end else begin
                sweep_d = sweep_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_RESET;
            sweep_q    <= '0;
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Entry storage needs no reset: occupancy alone decides what is valid.
    for (genvar gi = 0; gi < 2; gi++) begin : gen_fifo
        logic [31:0] entry_q;

        always_ff @(posedge CLK) begin
            if (push && (wr_ptr_q == 1'(gi))) begin
                entry_q <= bus.Q;
            end
        end

        assign entry_data[gi] = entry_q;
    end
endmodule

// File: tb/tb_sram_port_initiator.sv
// Bench for sram_port_initiator: behavioural SRAM, reference memory and an
// in-order scoreboard of expected read data.
module tb_sram_port_initiator;
    localparam int AW    = 5;
    localparam int DEPTH = 8;
    localparam int WORDS = 32;

    logic        CLK = 1'b0;
    logic        RST;
    logic        init_done;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_mem [WORDS];
    logic [31:0] sram [WORDS];
    logic        sram_loaded = 1'b0;
    logic [31:0] exp_q [$];

    sram_port_initiator_if #(.ADDR_WIDTH(AW)) bus ();

    sram_port_initiator #(
        .ADDR_WIDTH(AW),
        .DEPTH     (DEPTH),
        .INIT_EN   (1)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .bus      (bus.master),
        .init_done(init_done)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] fill_word(input int i);
        return 32'h5A00_0000 | (32'(i) * 32'h0001_0101);
    endfunction

    // Memory model: non-zero power-up contents so the sweep is observable.
    always @(posedge CLK) begin
        if (!sram_loaded) begin
            for (int i = 0; i < WORDS; i++) sram[i] <= fill_word(i);
            sram_loaded <= 1'b1;
        end else if (!bus.CEN) begin
            if (!bus.WEN) begin
                for (int b = 0; b < 4; b++)
                    if (!bus.BEN[b]) sram[bus.A][8*b +: 8] <= bus.D[8*b +: 8];
            end else begin
                bus.Q <= sram[bus.A];
            end
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        repeat (2) cyc();
        @(negedge CLK);
        checks++;
        if ({bus.req_ready, bus.rsp_valid, init_done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got ready/rvalid/done=%b want 000",
                     {bus.req_ready, bus.rsp_valid, init_done});
        end
        checks++;
        if ({bus.CEN, bus.WEN, bus.BEN} !== 6'b111111) begin
            errors++;
            $display("FAIL reset_port got CEN/WEN/BEN=%b want 111111", {bus.CEN, bus.WEN, bus.BEN});
        end
        checks++;
        if (bus.A !== 5'd0 || bus.D !== 32'd0) begin
            errors++;
            $display("FAIL reset_addr_data got A=%h D=%h want 0/0", bus.A, bus.D);
        end
        cyc();
        bus.req_valid = 1'b0;
        $display("reset: port idle, init_done=%b", init_done);
    endtask

    task automatic test_sweep();
        // A write request is held up throughout to show it is never accepted.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_be    = 4'hF;
        bus.req_addr  = 5'd31;
        bus.req_wdata = 32'hFFFF_FFFF;
        RST = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge CLK);
            checks++;
            if (bus.A !== AW'(i)) begin
                errors++;
                $display("FAIL sweep_addr got %0d want %0d", bus.A, i);
            end
            checks++;
            if ({bus.CEN, bus.WEN, bus.BEN, bus.req_ready, bus.rsp_valid, init_done} !== 9'b0) begin
                errors++;
                $display("FAIL sweep_ctrl cycle %0d got %b want 000000000", i,
                         {bus.CEN, bus.WEN, bus.BEN, bus.req_ready, bus.rsp_valid, init_done});
            end
            checks++;
            if (bus.D !== 32'd0) begin
                errors++;
                $display("FAIL sweep_data got %h want 0", bus.D);
            end
            $display("sweep: write 0 to A=%0d", bus.A);
            cyc();
        end
        bus.req_valid = 1'b0;
        @(negedge CLK);
        checks++;
        if ({init_done, bus.req_ready, bus.CEN} !== 3'b111) begin
            errors++;
            $display("FAIL sweep_done got done/ready/CEN=%b want 111", {init_done, bus.req_ready, bus.CEN});
        end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
        cyc();
    endtask

    task automatic test_write_read();
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_be    = 4'hF;
        bus.req_addr  = 5'h10;
        bus.req_wdata = 32'hDEAD_BEEF;
        @(negedge CLK);
        checks++;
        if ({bus.req_ready, bus.CEN, bus.WEN, bus.BEN} !== 7'b1000000 ||
            bus.A !== 5'h10 || bus.D !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL wr_port got rdy/CEN/WEN/BEN=%b A=%h D=%h want 1000000 10 deadbeef",
                     {bus.req_ready, bus.CEN, bus.WEN, bus.BEN}, bus.A, bus.D);
        end
        $display("write: A=10 D=deadbeef be=f");
        cyc();
        bus.req_we = 1'b0;
        @(negedge CLK);
        checks++;
        if ({bus.req_ready, bus.CEN, bus.WEN, bus.BEN} !== 7'b1010000) begin
            errors++;
            $display("FAIL rd_port got rdy/CEN/WEN/BEN=%b want 1010000",
                     {bus.req_ready, bus.CEN, bus.WEN, bus.BEN});
        end
        cyc();
        bus.req_valid = 1'b0;
        @(negedge CLK);
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_latency1 got rsp_valid=%b want 0", bus.rsp_valid);
        end
        cyc();
        @(negedge CLK);
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL rd_latency2 got valid=%b data=%h want 1 deadbeef", bus.rsp_valid, bus.rsp_rdata);
        end
        $display("read: A=10 -> %h", bus.rsp_rdata);
        cyc();
    endtask

    task automatic test_byte_enable();
        bit got = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_be    = 4'b0101;
        bus.req_addr  = 5'd3;
        bus.req_wdata = 32'h1122_3344;
        @(negedge CLK);
        checks++;
        if (bus.BEN !== 4'b1010) begin
            errors++;
            $display("FAIL be_map got BEN=%b want 1010", bus.BEN);
        end
        cyc();
        bus.req_we = 1'b0;
        cyc();
        bus.req_valid = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge CLK);
            if (bus.rsp_valid) begin
                got = 1'b1;
                checks++;
                if (bus.rsp_rdata !== 32'h0022_0044) begin
                    errors++;
                    $display("FAIL be_merge got %h want 00220044", bus.rsp_rdata);
                end
                $display("read: A=3 -> %h", bus.rsp_rdata);
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL be_timeout got no response want one");
        end
        cyc();
    endtask

    task automatic test_backpressure();
        logic [2:0] ready_seen;
        bit         drained = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 5'h10;
        @(negedge CLK); ready_seen[0] = bus.req_ready;
        cyc();
        bus.req_addr = 5'd3;
        @(negedge CLK); ready_seen[1] = bus.req_ready;
        cyc();
        // Write landing on an address whose read data is already in flight.
        bus.req_we    = 1'b1;
        bus.req_be    = 4'hF;
        bus.req_addr  = 5'h10;
        bus.req_wdata = 32'hCAFE_F00D;
        @(negedge CLK);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_write_ready got %b want 1", bus.req_ready);
        end
        cyc();
        bus.req_we   = 1'b0;
        bus.req_addr = 5'd5;
        @(negedge CLK); ready_seen[2] = bus.req_ready;
        checks++;
        if (ready_seen !== 3'b011) begin
            errors++;
            $display("FAIL bp_accept got ready third/second/first=%b want 011", ready_seen);
        end
        repeat (3) begin
            cyc();
            @(negedge CLK);
            checks++;
            if ({bus.req_ready, bus.rsp_valid} !== 2'b01) begin
                errors++;
                $display("FAIL bp_hold got ready/rvalid=%b want 01", {bus.req_ready, bus.rsp_valid});
            end
        end
        cyc();
        bus.rsp_ready = 1'b1;
        @(negedge CLK);
        checks++;
        if (bus.req_ready !== 1'b0 || bus.rsp_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL bp_first got ready=%b data=%h want 0 deadbeef", bus.req_ready, bus.rsp_rdata);
        end
        cyc();
        @(negedge CLK);
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_rdata !== 32'h0022_0044) begin
            errors++;
            $display("FAIL bp_second got ready=%b data=%h want 1 00220044", bus.req_ready, bus.rsp_rdata);
        end
        cyc();
        bus.req_valid = 1'b0;
        for (int k = 0; k < 20 && !drained; k++) begin
            cyc();
            if (exp_q.size() == 0 && !bus.rsp_valid) drained = 1'b1;
        end
        checks++;
        if (!drained) begin
            errors++;
            $display("FAIL bp_drain got %0d outstanding want 0", exp_q.size());
        end
        $display("backpressure: 3 reads + 1 write, drained=%b", drained);
    endtask

    task automatic test_random();
        bit drained = 1'b0;
        for (int n = 0; n < 400; n++) begin
            bus.req_valid = ($urandom_range(0, 3) != 0);
            bus.req_we    = 1'($urandom_range(0, 1));
            bus.req_be    = 4'($urandom_range(0, 15));
            bus.req_addr  = AW'($urandom_range(0, WORDS - 1));
            bus.req_wdata = $urandom;
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 20 && !drained; k++) begin
            cyc();
            if (exp_q.size() == 0 && !bus.rsp_valid) drained = 1'b1;
        end
        checks++;
        if (!drained) begin
            errors++;
            $display("FAIL rand_drain got %0d outstanding want 0", exp_q.size());
        end
        $display("random: 400 cycles, drained=%b", drained);
    endtask

    task automatic test_reset_mid();
        bit done = 1'b0;
        bus.rsp_ready = 1'b1;
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        repeat (3) cyc();
        @(negedge CLK);
        checks++;
        if (bus.A !== 5'd3 || bus.CEN !== 1'b0) begin
            errors++;
            $display("FAIL mid_sweep3 got A=%0d CEN=%b want 3 0", bus.A, bus.CEN);
        end
        #1 RST = 1'b1;
        cyc();
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if (bus.A !== 5'd0 || bus.CEN !== 1'b0 || init_done !== 1'b0) begin
            errors++;
            $display("FAIL sweep_restart got A=%0d CEN=%b done=%b want 0 0 0", bus.A, bus.CEN, init_done);
        end
        for (int i = 1; i < DEPTH; i++) begin
            cyc();
            @(negedge CLK);
            checks++;
            if (bus.A !== AW'(i)) begin
                errors++;
                $display("FAIL restart_addr got %0d want %0d", bus.A, i);
            end
        end
        cyc();
        @(negedge CLK);
        checks++;
        if (init_done !== 1'b1) begin
            errors++;
            $display("FAIL restart_done got %b want 1", init_done);
        end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
        cyc();
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 5'h10;
        cyc();
        bus.req_valid = 1'b0;
        cyc();
        @(negedge CLK);
        checks++;
        if (bus.rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL buffered_read got rsp_valid=%b want 1", bus.rsp_valid);
        end
        cyc();
        RST = 1'b1;
        @(negedge CLK);
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_rvalid got %b want 0", bus.rsp_valid);
        end
        cyc();
        RST = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge CLK);
        checks++;
        if ({bus.rsp_valid, bus.CEN, init_done} !== 3'b000 || bus.A !== 5'd0) begin
            errors++;
            $display("FAIL rst_flush got rvalid/CEN/done=%b A=%0d want 000 0",
                     {bus.rsp_valid, bus.CEN, init_done}, bus.A);
        end
        for (int k = 0; k < 12 && !done; k++) begin
            cyc();
            @(negedge CLK);
            if (init_done) done = 1'b1;
        end
        checks++;
        if (!done || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_resweep got done=%b rvalid=%b want 1 0", done, bus.rsp_valid);
        end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
        $display("reset mid-sweep and mid-read: sweep restarted, done=%b", done);
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_be    = 4'h0;
        bus.req_addr  = '0;
        bus.req_wdata = 32'd0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = fill_word(i);

        // Scoreboard: expected data is pushed when a read is accepted and
        // popped when a response is consumed.
        fork
            forever begin
                @(negedge CLK);
                if (RST) begin
                    exp_q.delete();
                end else begin
                    if (bus.rsp_valid && bus.rsp_ready) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL sb_unexpected got %h want no response", bus.rsp_rdata);
                        end else begin
                            logic [31:0] exp_word;
                            exp_word = exp_q.pop_front();
                            if (bus.rsp_rdata !== exp_word) begin
                                errors++;
                                $display("FAIL sb_rdata got %h want %h", bus.rsp_rdata, exp_word);
                            end
                        end
                    end
                    if (bus.req_valid && bus.req_ready) begin
                        if (bus.req_we) begin
                            for (int b = 0; b < 4; b++)
                                if (bus.req_be[b])
                                    ref_mem[bus.req_addr][8*b +: 8] = bus.req_wdata[8*b +: 8];
                        end else begin
                            exp_q.push_back(ref_mem[bus.req_addr]);
                        end
                    end
                end
            end
        join_none

        test_reset();
        test_sweep();
        test_write_read();
        test_byte_enable();
        test_backpressure();
        test_random();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
